// File: rtl/lm_sm_sequencer_pkg.sv
// Shared definitions for the LM/SM micro-sequencer: opcodes, IR field positions,
// sequencer state encoding and default address/offset parameters.
package lm_sm_sequencer_pkg;

    localparam logic [3:0] OP_LW = 4'b0100;
    localparam logic [3:0] OP_SW = 4'b0101;
    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    localparam int IR_OP_HI   = 15;
    localparam int IR_OP_LO   = 12;
    localparam int IR_RA_HI   = 11;
    localparam int IR_RA_LO   = 9;
    localparam int IR_MASK_HI = 7;
    localparam int IR_MASK_LO = 0;

    localparam int DEF_ADDR_STEP = 1;
    localparam int DEF_OFF_W     = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_t;

    function automatic logic is_multi_op(input logic [3:0] op);
        return (op == OP_LM) || (op == OP_SM);
    endfunction

endpackage

// File: rtl/lm_sm_sequencer_lsb_prio_enc8.sv
// Lowest-set-bit priority encoder: index and one-hot of the lowest set mask bit,
// plus a flag that exactly one bit is set.
module lsb_prio_enc8 (
    input  logic [7:0] mask,
    output logic [2:0] idx,
    output logic [7:0] onehot,
    output logic       single
);

    always_comb begin
        idx    = 3'd0;
        onehot = 8'd0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                idx       = 3'(i);
                onehot    = 8'd0;
                onehot[i] = 1'b1;
            end
        end
    end

    assign single = (mask != 8'd0) && ((mask & (mask - 8'd1)) == 8'd0);

endmodule

// File: rtl/lm_sm_sequencer.sv
// Decode-stage micro-sequencer: expands one LM/SM into one single-register
// micro-op per set mask bit, lowest register first, holding fetch until the last.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | waiting for an LM/SM with non-zero mask in IF/ID
//  ST_RUN  | issuing micro-ops from mask_q, one per non-held cycle
module lm_sm_sequencer
    import lm_sm_sequencer_pkg::*;
#(
    parameter int ADDR_STEP = DEF_ADDR_STEP,
    parameter int OFF_W     = DEF_OFF_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      if_id_ir,
    input  logic             if_id_valid,
    input  logic             pipe_hold,
    input  logic             flush,
    output logic             seq_busy,
    output logic             stall_fetch,
    output logic             id_bubble,
    output logic             uop_valid,
    output logic [15:0]      uop_ir,
    output logic [2:0]       uop_rd,
    output logic [OFF_W-1:0] uop_offset,
    output logic             uop_is_load,
    output logic             uop_last
);

    seq_state_t       state;
    logic [15:0]      ir_q;
    logic [7:0]       mask_q;
    logic [OFF_W-1:0] off_q;

    logic [2:0] enc_idx;
    logic [7:0] enc_onehot;
    logic       enc_single;
    logic       accept;
    logic       issue;

    // Bit 8 of the instruction is reserved zero and the stored mask lives in mask_q.
    logic unused_ir_bits;
    assign unused_ir_bits = ^{if_id_ir[8], ir_q[8:0]};

    lsb_prio_enc8 u_enc (
        .mask   (mask_q),
        .idx    (enc_idx),
        .onehot (enc_onehot),
        .single (enc_single)
    );

    assign accept = (state == ST_IDLE) && if_id_valid
                 && is_multi_op(if_id_ir[IR_OP_HI:IR_OP_LO])
                 && (if_id_ir[IR_MASK_HI:IR_MASK_LO] != 8'd0)
                 && !pipe_hold && !flush;

    assign issue = (state == ST_RUN) && !pipe_hold && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            ir_q   <= 16'd0;
            mask_q <= 8'd0;
            off_q  <= '0;
        end else begin
            if (flush) begin
                state  <= ST_IDLE;
                mask_q <= 8'd0;
            end else if (accept) begin
                state  <= ST_RUN;
                ir_q   <= if_id_ir;
                mask_q <= if_id_ir[IR_MASK_HI:IR_MASK_LO];
                off_q  <= '0;
            end else if (issue) begin
                mask_q <= mask_q & ~enc_onehot;
                off_q  <= off_q + OFF_W'(ADDR_STEP);
                if (enc_single) begin
                    state <= ST_IDLE;
                end
            end
        end
    end

    always_comb begin
        seq_busy    = 1'b0;
        stall_fetch = 1'b0;
        id_bubble   = 1'b0;
        uop_valid   = 1'b0;
        uop_ir      = 16'd0;
        uop_rd      = 3'd0;
        uop_offset  = '0;
        uop_is_load = 1'b0;
        uop_last    = 1'b0;
        case (state)
            ST_IDLE: begin
                id_bubble = accept;
            end
            ST_RUN: begin
                seq_busy    = 1'b1;
                id_bubble   = 1'b1;
                uop_valid   = !flush;
                uop_rd      = enc_idx;
                uop_offset  = off_q;
                uop_is_load = (ir_q[IR_OP_HI:IR_OP_LO] == OP_LM);
                uop_last    = enc_single;
                uop_ir      = {ir_q[IR_OP_HI:IR_RA_LO], 1'b0, enc_onehot};
                // Fetch resumes on the edge the last micro-op actually issues.
                stall_fetch = !flush && (pipe_hold || !enc_single);
            end
            default: begin
                seq_busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed plus randomized bench for lm_sm_sequencer against a queue-based
// model of the expected micro-op list.
module tb_lm_sm_sequencer;

    localparam int STEP = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] if_id_ir;
    logic        if_id_valid;
    logic        pipe_hold;
    logic        flush;
    logic        seq_busy;
    logic        stall_fetch;
    logic        id_bubble;
    logic        uop_valid;
    logic [15:0] uop_ir;
    logic [2:0]  uop_rd;
    logic [15:0] uop_offset;
    logic        uop_is_load;
    logic        uop_last;

    lm_sm_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_id_ir    (if_id_ir),
        .if_id_valid (if_id_valid),
        .pipe_hold   (pipe_hold),
        .flush       (flush),
        .seq_busy    (seq_busy),
        .stall_fetch (stall_fetch),
        .id_bubble   (id_bubble),
        .uop_valid   (uop_valid),
        .uop_ir      (uop_ir),
        .uop_rd      (uop_rd),
        .uop_offset  (uop_offset),
        .uop_is_load (uop_is_load),
        .uop_last    (uop_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] off;
    } uop_t;

    int          checks = 0;
    int          errors = 0;
    bit          m_busy = 1'b0;
    logic [15:0] m_ir = 16'd0;
    uop_t        m_q[$];
    int          n_issue, n_valid, n_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit accept_now();
        return !m_busy && if_id_valid && (if_id_ir[15:13] == 3'b011)
            && (if_id_ir[7:0] != 8'd0) && !pipe_hold && !flush;
    endfunction

    task automatic check_outputs();
        logic        e_busy, e_stall, e_bub, e_val, e_load, e_last;
        logic [2:0]  e_rd;
        logic [15:0] e_off, e_ir;
        logic [7:0]  one;
        e_busy = 0; e_stall = 0; e_bub = 0; e_val = 0; e_load = 0; e_last = 0;
        e_rd = 0; e_off = 0; e_ir = 0;
        if (m_busy) begin
            e_busy = 1;
            e_bub  = 1;
            e_val  = !flush;
            e_rd   = m_q[0].rd;
            e_off  = m_q[0].off;
            e_last = (m_q.size() == 1);
            e_load = (m_ir[15:12] == 4'b0110);
            one    = 8'd1 << e_rd;
            e_ir   = {m_ir[15:9], 1'b0, one};
            e_stall = flush ? 1'b0 : (pipe_hold ? 1'b1 : !e_last);
        end else begin
            e_bub = accept_now();
        end
        chk("seq_busy", 32'(seq_busy), 32'(e_busy));
        chk("stall_fetch", 32'(stall_fetch), 32'(e_stall));
        chk("id_bubble", 32'(id_bubble), 32'(e_bub));
        chk("uop_valid", 32'(uop_valid), 32'(e_val));
        if (e_val) begin
            chk("uop_rd", 32'(uop_rd), 32'(e_rd));
            chk("uop_offset", 32'(uop_offset), 32'(e_off));
            chk("uop_ir", 32'(uop_ir), 32'(e_ir));
            chk("uop_is_load", 32'(uop_is_load), 32'(e_load));
            chk("uop_last", 32'(uop_last), 32'(e_last));
        end
        if (uop_valid && !pipe_hold && !flush) n_issue++;
        if (uop_valid) n_valid++;
        if (stall_fetch) n_stall++;
    endtask

    task automatic model_edge(input bit acc);
        int k;
        if (m_busy) begin
            if (flush) begin
                m_busy = 0;
                m_q.delete();
            end else if (!pipe_hold) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_busy = 0;
            end
        end else if (acc) begin
            k = 0;
            for (int j = 0; j < 8; j++) begin
                if (if_id_ir[j]) begin
                    m_q.push_back('{rd: 3'(j), off: 16'(k * STEP)});
                    k++;
                end
            end
            m_busy = 1;
            m_ir   = if_id_ir;
        end
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic do_cycle(input bit v, input logic [15:0] ir, input bit hold, input bit fl);
        bit acc;
        if_id_valid = v;
        if_id_ir    = ir;
        pipe_hold   = hold;
        flush       = fl;
        #2;
        check_outputs();
        acc = accept_now();
        @(posedge clk);
        model_edge(acc);
        #1;
    endtask

    task automatic clr_counts();
        n_issue = 0; n_valid = 0; n_stall = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(seq_busy), 32'd0);
        chk({tag, "_stall"}, 32'(stall_fetch), 32'd0);
        chk({tag, "_bubble"}, 32'(id_bubble), 32'd0);
        chk({tag, "_valid"}, 32'(uop_valid), 32'd0);
        chk({tag, "_ir"}, 32'(uop_ir), 32'd0);
        chk({tag, "_rd"}, 32'(uop_rd), 32'd0);
        chk({tag, "_off"}, 32'(uop_offset), 32'd0);
        chk({tag, "_load"}, 32'(uop_is_load), 32'd0);
        chk({tag, "_last"}, 32'(uop_last), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [15:0] ir;
        rst_n = 1'b0; if_id_ir = 16'd0; if_id_valid = 1'b0; pipe_hold = 1'b0; flush = 1'b0;
        clr_counts();
        #2;
        check_all_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        do_cycle(0, 16'h0000, 0, 0);

        // LM R5 mask 0x05: R0 then R2
        do_cycle(1, 16'h6A05, 0, 0);
        clr_counts();
        do_cycle(1, 16'h1111, 0, 0);
        do_cycle(1, 16'h1111, 0, 0);
        chk("lm05_valid_cycles", 32'(n_valid), 32'd2);
        chk("lm05_stall_cycles", 32'(n_stall), 32'd1);
        do_cycle(0, 16'h0000, 0, 0);

        // SM mask 0xFF: eight micro-ops, fetch held for seven
        do_cycle(1, 16'h72FF, 0, 0);
        clr_counts();
        for (int i = 0; i < 8; i++) do_cycle(1, 16'h2222, 0, 0);
        chk("smff_valid_cycles", 32'(n_valid), 32'd8);
        chk("smff_stall_cycles", 32'(n_stall), 32'd7);
        do_cycle(0, 16'h0000, 0, 0);

        // Zero mask never starts a sequence
        clr_counts();
        do_cycle(1, 16'h6000, 0, 0);
        do_cycle(1, 16'h6000, 0, 0);
        chk("mask0_valid_cycles", 32'(n_valid), 32'd0);

        // SM 0x7281 with three held cycles on the second micro-op
        do_cycle(1, 16'h7281, 0, 0);
        clr_counts();
        do_cycle(1, 16'h3333, 0, 0);
        for (int i = 0; i < 3; i++) do_cycle(1, 16'h3333, 1, 0);
        do_cycle(1, 16'h3333, 0, 0);
        do_cycle(0, 16'h0000, 0, 0);
        chk("hold_issues", 32'(n_issue), 32'd2);
        chk("hold_valid_cycles", 32'(n_valid), 32'd5);

        // LM 0x68F0 flushed at the second micro-op
        do_cycle(1, 16'h68F0, 0, 0);
        clr_counts();
        do_cycle(1, 16'h4444, 0, 0);
        do_cycle(1, 16'h4444, 0, 1);
        for (int i = 0; i < 3; i++) do_cycle(1, 16'h4444, 0, 0);
        chk("flush_valid_cycles", 32'(n_valid), 32'd1);

        // Flush beats accept in IDLE
        do_cycle(1, 16'h6A05, 0, 1);
        clr_counts();
        do_cycle(0, 16'h0000, 0, 0);
        chk("flush_accept_busy", 32'(n_valid), 32'd0);

        // Asynchronous reset mid-sequence
        do_cycle(1, 16'h72FF, 0, 0);
        do_cycle(1, 16'h5555, 0, 0);
        do_cycle(1, 16'h5555, 0, 0);
        if_id_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        m_busy = 0;
        m_q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        clr_counts();
        for (int i = 0; i < 3; i++) do_cycle(1, 16'h5555, 0, 0);
        chk("post_rst_idle", 32'(n_valid), 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            r = $urandom;
            if (r[0]) begin
                ir = {3'b011, r[1], r[4:2], 1'b0, (r[7:5] == 3'd0) ? 8'h00 : r[15:8]};
            end else begin
                ir = 16'($urandom);
            end
            do_cycle(r[19:18] != 2'd0, ir, r[22:20] == 3'd0, r[27:23] == 5'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
